// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter: a stereo frame FIFO feeds a shift register that is clocked by
// oversampled codec SCLK/LRCLK. One frame is popped at the start of every left slot.
module i2s_slave_tx #(
   parameter int unsigned DATA_W      = 24,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_left,
   input  logic [DATA_W-1:0]             s_right,
   input  logic                          i2s_sclk,
   input  logic                          i2s_lrclk,
   output logic                          i2s_dout,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          running
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_LEFT,
      ST_RUN
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [SYNC_STAGES-1:0]  r_sclk_sync;
   logic [SYNC_STAGES-1:0]  r_lr_sync;
   logic                    r_sclk_prev;
   logic                    r_lr_prev;
   logic                    w_sclk_s;
   logic                    w_lr_s;
   logic                    w_sfall;
   logic                    w_boundary;
   logic                    w_left_bnd;
   logic                    w_right_bnd;

   logic [DATA_W-1:0]       r_mem_l [FIFO_DEPTH];
   logic [DATA_W-1:0]       r_mem_r [FIFO_DEPTH];
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [LW-1:0]           r_level;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_act;
   logic                    w_ur_set;

   logic [DATA_W-1:0]       r_shreg;
   logic [DATA_W-1:0]       r_rhold;
   logic                    r_dout;
   logic                    r_underrun;

   // ---------------------------------------------------------------- synchronizers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sclk_sync <= '0;
         r_lr_sync   <= '0;
         r_sclk_prev <= 1'b0;
         r_lr_prev   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
         r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
         r_sclk_prev <= w_sclk_s;
         if (w_sfall) begin
            r_lr_prev <= w_lr_s;
         end
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_lr_s      = r_lr_sync[SYNC_STAGES-1];
   assign w_sfall     = r_sclk_prev & ~w_sclk_s;
   assign w_boundary  = w_sfall & (w_lr_s != r_lr_prev);
   assign w_left_bnd  = w_boundary & ~w_lr_s;
   assign w_right_bnd = w_boundary &  w_lr_s;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // w_act marks a cycle in which the shift engine runs; WAIT_LEFT gets its first
   // one on the left boundary that also moves it into RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_act       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_WAIT_LEFT;
            end
         end
         ST_WAIT_LEFT: begin
            if (w_left_bnd) begin
               w_state_nxt = ST_RUN;
               w_act       = 1'b1;
            end
         end
         ST_RUN: begin
            w_act = w_sfall;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (!enable) begin
         w_state_nxt = ST_IDLE;
         w_act       = 1'b0;
      end
   end

   // ---------------------------------------------------------------- FIFO
   assign w_empty  = (r_level == '0);
   assign s_ready  = (r_level != LVL_FULL);
   assign w_push   = s_valid & s_ready;
   assign w_pop    = w_act & w_left_bnd & ~w_empty;
   assign w_ur_set = w_act & w_left_bnd &  w_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_l[i] <= '0;
            r_mem_r[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_mem_l[r_wptr] <= s_left;
            r_mem_r[r_wptr] <= s_right;
            r_wptr          <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ---------------------------------------------------------------- shift engine
   // The reload on a boundary happens after the shift-out, which yields the
   // one-bit I2S delay without any extra counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shreg    <= '0;
         r_rhold    <= '0;
         r_dout     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_ur_set;
         if (!enable) begin
            r_shreg <= '0;
            r_rhold <= '0;
            r_dout  <= 1'b0;
         end else if (w_act) begin
            r_dout <= r_shreg[DATA_W-1];
            if (w_left_bnd) begin
               if (w_empty) begin
                  r_shreg <= '0;
                  r_rhold <= '0;
               end else begin
                  r_shreg <= r_mem_l[r_rptr];
                  r_rhold <= r_mem_r[r_rptr];
               end
            end else if (w_right_bnd) begin
               r_shreg <= r_rhold;
            end else begin
               r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            end
         end
      end
   end

   assign i2s_dout   = r_dout;
   assign underrun   = r_underrun;
   assign running    = (r_state == ST_RUN);
   assign fifo_level = r_level;

endmodule
